div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle integer divider serving the execute stage; it is the responder side of the execute stage's divide request/stall handshake.
- Execute raises start_i with operands and holds stallreq high until ready_o. The divider then returns {remainder, quotient} for the HI/LO write.
- Radix-2 restoring algorithm, one quotient bit per cycle, with signed and unsigned modes. Supports annul (flush) mid-operation.

Parameters:
DATA_W, 32, operand width; result_o is 2*DATA_W.
CNT_W, 6, iteration-counter width; must hold the value DATA_W.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; synchronous, active-high
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU)
opdata1_i  input  DATA_W  dividend
opdata2_i  input  DATA_W  divisor
start_i  input  1  request; held high by execute until ready_o is seen
annul_i  input  1  abort the current operation (pipeline flush or branch-slot cancel)
result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}
ready_o  output  1  result valid

Behaviour:
- Reset is synchronous, active-high, and has priority over everything:
  - state = FREE, cnt = 0, dividend register = 0.
  - result_o = 0, ready_o = 0.
- All outputs are registered.
- FSM states: FREE, BYZERO, ON, END.
- FREE:
  - ready_o = 0, result_o = 0.
  - On start_i & !annul_i: opdata2_i == 0 goes to BYZERO; otherwise go to ON.
  - On entry to ON:
    - Latch the operand magnitudes. In signed mode, a negative operand is two's-complemented; in unsigned mode operands are taken raw.
    - Latch the sign flags and signed_div_i.
    - dividend[64:0] = {32'b0, |op1|, 1'b0}; cnt = 0.
  - Operands are sampled only in this transition; later operand changes are ignored.
- BYZERO: next edge goes to END with dividend = 0, so the result is all-zero.
- ON:
  - annul_i = 1 goes to FREE next edge with result_o = 0, ready_o = 0. The iteration is discarded.
  - Otherwise, while cnt != DATA_W, perform one step:
    - tmp = {1'b0, dividend[63:32]} − {1'b0, divisor}.
    - If tmp[32] = 1: dividend = {dividend[63:0], 1'b0}.
    - Else: dividend = {tmp[31:0], dividend[31:0], 1'b1}.
    - cnt++.
  - When cnt == DATA_W, apply sign correction and go to END:
    - quotient = dividend[31:0], negated if signed and sign1 ^ sign2.
    - remainder = dividend[64:33], negated if signed and sign1. The remainder takes the dividend's sign; quotient truncates toward zero.
  - start_i is ignored while in ON.
- END:
  - result_o = {remainder, quotient}; ready_o = 1, registered.
  - Stays in END while start_i = 1.
  - When start_i = 0, go to FREE next edge; ready_o = 0 and result_o = 0.
- Latency, with start sampled at edge N:
  - Normal divide: ready_o visible after edge N+34 (1 setup, 32 iterations, 1 correction, then END registers the outputs).
  - Divide by zero: ready_o visible after edge N+2.
- Edge cases:
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0. It wraps; no exception.
  - start_i & annul_i together in FREE: the request is not accepted.
  - annul_i in END or BYZERO is ignored; the handshake completes normally.
  - Reset in any state returns to FREE on the next edge.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- When defined: in FREE, on acceptance with divisor != 0 and |op1| < |op2|, go directly to END.
  - Quotient = 0; remainder = opdata1_i as given.
  - ready_o is visible after edge N+2.
- When undefined: every nonzero-divisor request takes the full 34-edge path.
- The results are identical in both builds.

Decomposition:
- Shared defines header:
  - State encodings DivFree, DivByZero, DivOn, DivEnd (2 bits).
  - DivResultReady / DivResultNotReady.
  - DivStart / DivStop.
  - ZeroWord, DoubleRegBus widths.
- Single module: FSM plus datapath. No sub-module; the step subtractor is inline.

Test Plan:
- Unsigned 7 / 2 → result_o = {0x00000001, 0x00000003}; ready_o is first high after edge N+34 and is held until start_i drops, then 0.
- Signed 0xFFFFFFF9 (−7) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Any / 0 → result_o = 0 with ready after edge N+2.
- annul_i pulsed at iteration 10 → FREE next edge, ready_o never rises. A back-to-back new start (100 / 7) → {2, 14} at full latency.
- rst asserted at iteration 20 → all outputs 0 next edge. A following request completes correctly.
- 3 / 7 unsigned → {3, 0}. Ready after N+2 with DIV_EARLY_EXIT_EN defined, N+34 without.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared constants for the multi-cycle divider: FSM state encodings,
// handshake levels and bus widths.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam int          RegBusW       = 32;
  localparam int          DoubleRegBusW = 2 * RegBusW;
  localparam logic [31:0] ZeroWord      = 32'h0000_0000;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider (DIV/DIVU) with start/ready handshake and annul.
// Optional build macro DIV_EARLY_EXIT_EN shortcuts requests where |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  div_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [2*DATA_W:0]     dividend_q;
  logic [DATA_W-1:0]     divisor_q;
  logic                  sign1_q;
  logic                  sign2_q;
  logic                  signed_q;
  logic [2*DATA_W-1:0]   result_q;
  logic                  ready_q;

  logic                  sign1_d;
  logic                  sign2_d;
  logic [DATA_W-1:0]     abs1_d;
  logic [DATA_W-1:0]     abs2_d;
  logic [DATA_W:0]       step_d;
  logic [DATA_W-1:0]     quot_d;
  logic [DATA_W-1:0]     rem_d;
  logic                  accept_d;
  logic                  early_d;

  always_comb begin
    sign1_d  = signed_div_i & opdata1_i[DATA_W-1];
    sign2_d  = signed_div_i & opdata2_i[DATA_W-1];
    abs1_d   = sign1_d ? -opdata1_i : opdata1_i;
    abs2_d   = sign2_d ? -opdata2_i : opdata2_i;
    accept_d = (start_i == DivStart) && !annul_i;
    step_d   = {1'b0, dividend_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    quot_d   = (signed_q & (sign1_q ^ sign2_q)) ? -dividend_q[DATA_W-1:0]
                                                : dividend_q[DATA_W-1:0];
    rem_d    = (signed_q & sign1_q) ? -dividend_q[2*DATA_W:DATA_W+1]
                                    : dividend_q[2*DATA_W:DATA_W+1];
`ifdef DIV_EARLY_EXIT_EN
    early_d  = (abs1_d < abs2_d);
`else
    early_d  = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      signed_q   <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      case (state_q)
        DivFree: begin
          result_q <= '0;
          ready_q  <= DivResultNotReady;
          if (accept_d) begin
            if (opdata2_i == '0) begin
              state_q <= DivByZero;
            end else begin
              state_q   <= DivOn;
              divisor_q <= abs2_d;
              sign1_q   <= sign1_d;
              sign2_q   <= sign2_d;
              signed_q  <= signed_div_i;
              if (early_d) begin
                // Preload the finished form (q = 0, r = |op1|) and jump straight
                // to the correction cycle, which restores the dividend's sign.
                cnt_q      <= CNT_W'(DATA_W);
                dividend_q <= {abs1_d, {DATA_W{1'b0}}, 1'b0};
              end else begin
                cnt_q      <= '0;
                dividend_q <= {{DATA_W{1'b0}}, abs1_d, 1'b0};
              end
            end
          end
        end

        DivByZero: begin
          state_q    <= DivEnd;
          dividend_q <= '0;
        end

        DivOn: begin
          if (annul_i) begin
            state_q  <= DivFree;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
          end else if (cnt_q != CNT_W'(DATA_W)) begin
            if (step_d[DATA_W]) begin
              dividend_q <= {dividend_q[2*DATA_W-1:0], 1'b0};
            end else begin
              dividend_q <= {step_d[DATA_W-1:0], dividend_q[DATA_W-1:0], 1'b1};
            end
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            dividend_q[DATA_W-1:0]          <= quot_d;
            dividend_q[2*DATA_W:DATA_W+1]   <= rem_d;
            cnt_q                           <= '0;
            state_q                         <= DivEnd;
          end
        end

        DivEnd: begin
          result_q <= {dividend_q[2*DATA_W:DATA_W+1], dividend_q[DATA_W-1:0]};
          ready_q  <= DivResultReady;
          if (start_i == DivStop) begin
            state_q  <= DivFree;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
          end
        end

        default: state_q <= DivFree;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: results, latency, handshake,
// annul and reset behaviour.
module tb_div_unit;

`ifdef DIV_EARLY_EXIT_EN
  localparam int EXIT_LAT = 2;
`else
  localparam int EXIT_LAT = 34;
`endif

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result_o;
  logic        ready_o;

  int total;
  int bad;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div),
    .opdata1_i   (op1),
    .opdata2_i   (op2),
    .start_i     (start),
    .annul_i     (annul),
    .result_o    (result_o),
    .ready_o     (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full handshake: request, measure edges to ready, hold, release.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat);
    int n;
    signed_div = sgn;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    annul      = 1'b0;
    tick();
    n = 0;
    while (ready_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_res"}, result_o, exp);
    op1   = $urandom;
    op2   = $urandom;
    annul = 1'b1;
    tick();
    chk({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
    chk({tag, "_hold_res"}, result_o, exp);
    annul = 1'b0;
    start = 1'b0;
    tick();
    chk({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
    chk({tag, "_drop_res"}, result_o, 64'd0);
  endtask

  initial begin
    int hits;
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    signed_div = 1'b0;
    op1        = '0;
    op2        = '0;
    start      = 1'b0;
    annul      = 1'b0;
    repeat (3) tick();
    chk("reset_rdy", 64'(ready_o), 64'd0);
    chk("reset_res", result_o, 64'd0);
    rst = 1'b0;
    tick();

    do_div("u7_2",      1'b0, 32'd7,        32'd2,        {32'd1,        32'd3},        34);
    do_div("s-7_2",     1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 34);
    do_div("uffff_1",   1'b0, 32'hFFFFFFFF, 32'd1,        {32'd0,        32'hFFFFFFFF}, 34);
    do_div("s_minovf",  1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0,        32'h80000000}, 34);
    do_div("u_byzero",  1'b0, 32'd5,        32'd0,        64'd0,                        2);
    do_div("s_byzero",  1'b1, 32'hFFFFFFF0, 32'd0,        64'd0,                        2);
    do_div("s-20_6",    1'b1, 32'hFFFFFFEC, 32'd6,        {32'hFFFFFFFE, 32'hFFFFFFFD}, 34);
    do_div("s20_-6",    1'b1, 32'd20,       32'hFFFFFFFA, {32'd2,        32'hFFFFFFFD}, 34);
    do_div("u3_7",      1'b0, 32'd3,        32'd7,        {32'd3,        32'd0},        EXIT_LAT);
    do_div("s-3_7",     1'b1, 32'hFFFFFFFD, 32'd7,        {32'hFFFFFFFD, 32'd0},        EXIT_LAT);

    // start together with annul in FREE must not be accepted
    signed_div = 1'b0;
    op1        = 32'd7;
    op2        = 32'd2;
    start      = 1'b1;
    annul      = 1'b1;
    hits       = 0;
    repeat (40) begin
      tick();
      if (ready_o === 1'b1) hits++;
    end
    chk("start_annul_free", 64'(hits), 64'd0);
    start = 1'b0;
    annul = 1'b0;
    tick();

    // annul at iteration 10
    op1   = 32'd50;
    op2   = 32'd3;
    start = 1'b1;
    tick();
    repeat (10) tick();
    annul = 1'b1;
    start = 1'b0;
    tick();
    chk("annul_rdy", 64'(ready_o), 64'd0);
    chk("annul_res", result_o, 64'd0);
    annul = 1'b0;
    hits  = 0;
    repeat (40) begin
      tick();
      if (ready_o === 1'b1) hits++;
    end
    chk("annul_no_ready", 64'(hits), 64'd0);
    do_div("after_annul", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34);

    // reset at iteration 20
    op1   = 32'd1000;
    op2   = 32'd10;
    start = 1'b1;
    tick();
    repeat (20) tick();
    rst   = 1'b1;
    start = 1'b0;
    tick();
    chk("rst_mid_rdy", 64'(ready_o), 64'd0);
    chk("rst_mid_res", result_o, 64'd0);
    rst = 1'b0;
    tick();
    do_div("after_rst", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 34);

    // reset while holding a result in END
    op1   = 32'd9;
    op2   = 32'd4;
    start = 1'b1;
    hits  = 0;
    while (ready_o !== 1'b1 && hits < 100) begin
      tick();
      hits++;
    end
    chk("end_res_9_4", result_o, {32'd1, 32'd2});
    rst = 1'b1;
    tick();
    chk("rst_end_rdy", 64'(ready_o), 64'd0);
    chk("rst_end_res", result_o, 64'd0);
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
